// File: rtl/raycast_pkg.sv
// Shared definitions for the ray-cast DDA output path.
//   - Default screen geometry used by the packer parameters.
//   - Bit positions of each field inside the 38-bit DDA-out word.
//   - dda_word_t: packed view of that word (MSB first).
//   - head_state_e: output-side state of the word buffer.
//   - clamp_line_height: line height clamp to the screen height, truncated to 8 bits.
package raycast_pkg;

  localparam int SCREEN_WIDTH_DEF  = 320;
  localparam int SCREEN_HEIGHT_DEF = 180;

  localparam int DDA_WORD_W = 38;
  localparam int HCOUNT_LSB = 29;
  localparam int LH_LSB     = 21;
  localparam int WTYPE_BIT  = 20;
  localparam int MAP_LSB    = 16;

  typedef struct packed {
    logic [8:0]  hcount;     // [37:29]
    logic [7:0]  lh8;        // [28:21]
    logic        wall_type;  // [20]
    logic [3:0]  map_data;   // [19:16]
    logic [15:0] wall_x;     // [15:0]
  } dda_word_t;

  typedef enum logic {
    ST_EMPTY      = 1'b0,
    ST_HEAD_VALID = 1'b1
  } head_state_e;

  // The receiver halves this value to place the wall slice around the
  // horizon; clamping to the screen height keeps that math non-negative.
  function automatic logic [7:0] clamp_line_height(input logic [15:0] lh,
                                                   input logic [15:0] ceil_h);
    logic [15:0] clamped;
    clamped = (lh > ceil_h) ? ceil_h : lh;
    return clamped[7:0];
  endfunction

endpackage

// File: rtl/ray_word_fifo.sv
// Synchronous first-word-fall-through buffer for packed DDA words.
// The head entry is presented from registered storage, so a word pushed into
// an empty buffer is visible on head_data_out one cycle later.
// Ports:
//   clk_in          clock
//   rst_n_in        asynchronous active-low reset (empties the buffer)
//   push_in         write data_in this cycle (caller guarantees space or a same-cycle pop)
//   data_in         word to store
//   pop_in          remove the head entry (ignored when empty)
//   head_valid_out  head entry present
//   head_data_out   head entry contents
//   count_out       number of stored entries
module ray_word_fifo
  import raycast_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 39
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push_in,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop_in,
  output logic                       head_valid_out,
  output logic [WIDTH-1:0]           head_data_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  head_state_e      state_q, state_d;
  logic             pop_ok;

  assign pop_ok = pop_in && (state_q == ST_HEAD_VALID);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;

    if (push_in) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_in && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_in && pop_ok) begin
      count_d = count_q - CW'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (push_in) begin
          state_d = ST_HEAD_VALID;
        end
      end
      ST_HEAD_VALID: begin
        // Popping the only entry with nothing arriving empties the buffer;
        // otherwise the next stored word falls through to the head.
        if (pop_ok && !push_in && (count_q == CW'(1))) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Storage needs no reset: entries are only observed once the pointers
  // say they were written. When full with a simultaneous pop, wr_ptr equals
  // rd_ptr; the old head is still read this cycle and replaced at the edge.
  always_ff @(posedge clk_in) begin
    if (push_in) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign head_valid_out = (state_q == ST_HEAD_VALID);
  assign head_data_out  = mem_q[rd_ptr_q];
  assign count_out      = count_q;

endmodule

// File: rtl/dda_axis_packer.sv
// Transmit end of the DDA-out stream: packs per-column DDA results into
// 38-bit words, buffers them and drives them AXI-Stream style into the
// DDA-out FIFO, tagging the last column of each frame with tlast.
// Optional build macro: DDA_PACKER_STATS_EN adds frames_sent_out and
// stall_cycles_out saturating counters.
// Ports:
//   pixel_clk_in         clock
//   rst_n_in             asynchronous active-low reset
//   valid_in             DDA result valid
//   hcount_ray_in        column index
//   lineHeight_in        projected line height (clamped to SCREEN_HEIGHT)
//   wallType_in          0 = X wall, 1 = Y wall
//   mapData_in           map cell value
//   wallX_in             wall hit fraction
//   dda_ready_out        DDA may issue new rays (registered)
//   dda_fifo_tvalid_out  word available
//   dda_fifo_tdata_out   packed word
//   dda_fifo_tlast_out   last column of frame
//   dda_fifo_tready_in   downstream accepts word
//   frame_done_out       pulse the cycle after the tlast handshake
//   overflow_out         sticky: a result arrived while the buffer was full
//   frames_sent_out      (stats build) frames completed, saturating
//   stall_cycles_out     (stats build) cycles with tvalid && !tready, saturating
module dda_axis_packer
  import raycast_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int DEPTH         = 8,
  parameter int SLACK         = 3
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        valid_in,
  input  logic [8:0]  hcount_ray_in,
  input  logic [15:0] lineHeight_in,
  input  logic        wallType_in,
  input  logic [3:0]  mapData_in,
  input  logic [15:0] wallX_in,
  output logic        dda_ready_out,
  output logic        dda_fifo_tvalid_out,
  output logic [37:0] dda_fifo_tdata_out,
  output logic        dda_fifo_tlast_out,
  input  logic        dda_fifo_tready_in,
  output logic        frame_done_out,
  output logic        overflow_out
`ifdef DDA_PACKER_STATS_EN
  ,
  output logic [15:0] frames_sent_out,
  output logic [15:0] stall_cycles_out
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  dda_word_t          word_in;
  logic               word_last;
  logic               head_valid;
  logic [DDA_WORD_W:0] head_data;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      count_after;

  logic               pop;
  logic               full;
  logic               accept;
  logic               drop;

  logic [8:0]         col_q, col_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  always_comb begin
    word_in           = '0;
    word_in.hcount    = hcount_ray_in;
    word_in.lh8       = clamp_line_height(lineHeight_in, 16'(SCREEN_HEIGHT));
    word_in.wall_type = wallType_in;
    word_in.map_data  = mapData_in;
    word_in.wall_x    = wallX_in;
  end

  assign pop    = head_valid && dda_fifo_tready_in;
  assign full   = (fifo_count == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so a full buffer still takes the word.
  assign accept = valid_in && (!full || pop);
  assign drop   = valid_in && !accept;

  // Frames are delimited by the count of accepted words, not hcount values,
  // so the DDA may deliver columns out of order.
  assign word_last = (col_q == 9'(SCREEN_WIDTH - 1));

  always_comb begin
    col_d        = col_q;
    count_after  = fifo_count;
    ready_d      = ready_q;
    overflow_d   = overflow_q | drop;
    frame_done_d = pop && head_data[0];

    if (accept) begin
      col_d = word_last ? 9'd0 : col_q + 9'd1;
    end

    if (accept && !pop) begin
      count_after = fifo_count + CW'(1);
    end else if (!accept && pop) begin
      count_after = fifo_count - CW'(1);
    end

    // Registered from the post-update occupancy so the DDA sees the drop
    // while SLACK entries remain for rays already in its pipeline.
    ready_d = ((CW'(DEPTH) - count_after) > CW'(SLACK));
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col_q        <= '0;
      ready_q      <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      ready_q      <= ready_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  ray_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DDA_WORD_W + 1)
  ) u_fifo (
    .clk_in         (pixel_clk_in),
    .rst_n_in       (rst_n_in),
    .push_in        (accept),
    .data_in        ({word_in, word_last}),
    .pop_in         (pop),
    .head_valid_out (head_valid),
    .head_data_out  (head_data),
    .count_out      (fifo_count)
  );

  assign dda_ready_out       = ready_q;
  assign dda_fifo_tvalid_out = head_valid;
  assign dda_fifo_tdata_out  = head_data[DDA_WORD_W:1];
  // Gated so tlast reads 0 whenever no word is offered (including reset).
  assign dda_fifo_tlast_out  = head_valid && head_data[0];
  assign frame_done_out      = frame_done_q;
  assign overflow_out        = overflow_q;

`ifdef DDA_PACKER_STATS_EN
  logic [15:0] frames_q, frames_d;
  logic [15:0] stalls_q, stalls_d;

  always_comb begin
    frames_d = frames_q;
    stalls_d = stalls_q;
    if (frame_done_q && (frames_q != 16'hFFFF)) begin
      frames_d = frames_q + 16'd1;
    end
    if (head_valid && !dda_fifo_tready_in && (stalls_q != 16'hFFFF)) begin
      stalls_d = stalls_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frames_q <= '0;
      stalls_q <= '0;
    end else begin
      frames_q <= frames_d;
      stalls_q <= stalls_d;
    end
  end

  assign frames_sent_out  = frames_q;
  assign stall_cycles_out = stalls_q;
`endif

endmodule

// File: tb/tb_dda_axis_packer.sv
module tb_dda_axis_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [8:0]  hcount;
  logic [15:0] lh;
  logic        wtype;
  logic [3:0]  mapd;
  logic [15:0] wallx;
  logic        dda_ready;
  logic        tvalid;
  logic [37:0] tdata;
  logic        tlast;
  logic        tready;
  logic        frame_done;
  logic        overflow;
`ifdef DDA_PACKER_STATS_EN
  logic [15:0] frames_sent;
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  dda_axis_packer dut (
    .pixel_clk_in        (clk),
    .rst_n_in            (rst_n),
    .valid_in            (valid_in),
    .hcount_ray_in       (hcount),
    .lineHeight_in       (lh),
    .wallType_in         (wtype),
    .mapData_in          (mapd),
    .wallX_in            (wallx),
    .dda_ready_out       (dda_ready),
    .dda_fifo_tvalid_out (tvalid),
    .dda_fifo_tdata_out  (tdata),
    .dda_fifo_tlast_out  (tlast),
    .dda_fifo_tready_in  (tready),
    .frame_done_out      (frame_done),
    .overflow_out        (overflow)
`ifdef DDA_PACKER_STATS_EN
    ,
    .frames_sent_out     (frames_sent),
    .stall_cycles_out    (stall_cycles)
`endif
  );

  typedef struct {
    logic [37:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   beats = 0;
  int   lasts = 0;
  int   fds = 0;
  int   col_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [37:0] pack(input logic [8:0] h, input logic [15:0] l,
                                       input logic w, input logic [3:0] m,
                                       input logic [15:0] x);
    logic [7:0] l8;
    l8 = (l > 16'd180) ? 8'd180 : l[7:0];
    return {h, l8, w, m, x};
  endfunction

  // Drives one result for a single cycle (entered at posedge+1, returns at posedge+1).
  task automatic send(input logic [8:0] h, input logic [15:0] l, input logic w,
                      input logic [3:0] m, input logic [15:0] x, input bit accepted);
    exp_t e;
    valid_in = 1'b1;
    hcount   = h;
    lh       = l;
    wtype    = w;
    mapd     = m;
    wallx    = x;
    if (accepted) begin
      e.data = pack(h, l, w, m, x);
      e.last = (col_model == 319);
      sb.push_back(e);
      col_model = (col_model == 319) ? 0 : col_model + 1;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_col(input int i, input bit accepted);
    send(9'(i % 320), 16'(40 + (i % 150)), 1'(i), 4'(i), 16'(i * 13), accepted);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    col_model = 0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each handshake with the scoreboard, checks frame_done
  // timing and AXIS hold rules. Flushes the scoreboard while in reset.
  initial begin
    logic        fd_exp;
    logic        stall_prev;
    logic [37:0] prev_data;
    logic        prev_last;
    exp_t        e;
    fd_exp = 1'b0;
    stall_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        fd_exp = 1'b0;
        stall_prev = 1'b0;
      end else begin
        check("frame_done", 64'(frame_done), 64'(fd_exp));
        if (frame_done) fds++;
        if (stall_prev) begin
          check("hold_tvalid", 64'(tvalid), 64'd1);
          check("hold_tdata", 64'(tdata), 64'(prev_data));
          check("hold_tlast", 64'(tlast), 64'(prev_last));
        end
        fd_exp = 1'b0;
        if (tvalid && tready) begin
          beats++;
          if (tlast) lasts++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %0h expected none", tdata);
          end else begin
            e = sb.pop_front();
            $display("beat data=%h last=%0b exp=%h/%0b", tdata, tlast, e.data, e.last);
            check("beat_data", 64'(tdata), 64'(e.data));
            check("beat_last", 64'(tlast), 64'(e.last));
          end
          fd_exp = tlast;
        end
        stall_prev = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] lh_vec [6] = '{16'd900, 16'd0, 16'd180, 16'd181, 16'd179, 16'hFFFF};
  logic [7:0]  lh_exp [6] = '{8'd180, 8'd0, 8'd180, 8'd180, 8'd179, 8'd180};

  initial begin
    int b_beats, b_lasts, b_fds;
    rst_n = 1'b0;
    valid_in = 1'b0;
    hcount = '0;
    lh = '0;
    wtype = 1'b0;
    mapd = '0;
    wallx = '0;
    tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 64'(dda_ready), 64'd1);

    // 1: full frame, lh=100, tready=1
    tready = 1'b1;
    b_beats = beats; b_lasts = lasts; b_fds = fds;
    for (int i = 0; i < 320; i++) send(9'(i), 16'd100, 1'(i), 4'(i), 16'(i * 7), 1'b1);
    drain();
    check("t1_beats", 64'(beats - b_beats), 64'd320);
    check("t1_tlast_count", 64'(lasts - b_lasts), 64'd1);
    check("t1_frame_done_count", 64'(fds - b_fds), 64'd1);

    // 2: clamp and first-word latency
    for (int k = 0; k < 6; k++) begin
      send(9'(k), lh_vec[k], 1'b0, 4'd3, 16'h1234, 1'b1);
      check("latency_tvalid", 64'(tvalid), 64'd1);
      check("lh_clamp", 64'(tdata[28:21]), 64'(lh_exp[k]));
    end
    drain();

    // 3: backpressure, ready falls once free <= 3
    do_reset();
    tready = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      send_col(n, 1'b1);
      check("bp_ready", 64'(dda_ready), (n <= 4) ? 64'd1 : 64'd0);
    end
    check("bp_no_overflow", 64'(overflow), 64'd0);
    check("bp_tvalid", 64'(tvalid), 64'd1);
    tready = 1'b1;
    drain();
    check("bp_ready_back", 64'(dda_ready), 64'd1);

    // 4: forced valid into a full buffer
    do_reset();
    tready = 1'b0;
    b_lasts = lasts; b_fds = fds;
    for (int n = 0; n < 10; n++) send_col(n, n < 8);
    check("ovf_set", 64'(overflow), 64'd1);
    tready = 1'b1;
    for (int n = 8; n < 320; n++) send_col(n, 1'b1);
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_tlast_count", 64'(lasts - b_lasts), 64'd1);
    check("ovf_frame_done_count", 64'(fds - b_fds), 64'd1);

    // 5: asynchronous reset mid-frame
    do_reset();
    tready = 1'b1;
    for (int n = 0; n < 150; n++) send_col(n, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(tvalid), 64'd0);
    check("arst_tlast", 64'(tlast), 64'd0);
    check("arst_frame_done", 64'(frame_done), 64'd0);
    col_model = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_beats = beats; b_lasts = lasts; b_fds = fds;
    for (int n = 0; n < 320; n++) send_col(n + 7, 1'b1);
    drain();
    check("arst_beats", 64'(beats - b_beats), 64'd320);
    check("arst_tlast_count", 64'(lasts - b_lasts), 64'd1);
    check("arst_frame_done_count", 64'(fds - b_fds), 64'd1);

`ifdef DDA_PACKER_STATS_EN
    // 6: statistics counters
    do_reset();
    tready = 1'b1;
    for (int n = 0; n < 639; n++) send_col(n, 1'b1);
    drain();
    tready = 1'b0;
    send_col(639, 1'b1);
    repeat (10) @(posedge clk);
    #1 tready = 1'b1;
    drain();
    check("stats_frames", 64'(frames_sent), 64'd2);
    check("stats_stalls", 64'(stall_cycles), 64'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
